uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART byte transmitter among `N_REQ` requesters. Each requester offers packets as byte streams with a `last` marker. The arbiter grants one requester for a whole packet and forwards its bytes through a registered one-entry output stage to the transmitter's valid/ready input. It sits between the protocol/debug sources and the single TX serializer.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 47 ++++
 rtl/uart_tx_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART TX arbiter slice.
//   state_t          : arbiter FSM states (IDLE, XFER)
//   BYTE_W           : width of one UART byte
//   DEFAULT_TIMEOUT  : default stall limit in cycles for the optional
//                      stall timer (UART_TX_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Selects the first asserted request at or
// after the pointer, searching upward and wrapping from N-1 back to 0.
// Ports:
//   req   [N-1:0]     in  : request vector
//   ptr   [PTR_W-1:0] in  : search start index (always < N)
//   pick  [N-1:0]     out : one-hot selected request, zero if none
//   any               out : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             any
);

    localparam logic [PTR_W:0] N_W = (PTR_W + 1)'(N);

    // One extra bit on the slot index so ptr+k can be compared against N and
    // wrapped explicitly; this keeps non-power-of-two N correct.
    always_comb begin
        logic [PTR_W:0] slot;
        logic           found;
        pick  = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < N; k++) begin
            slot = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (slot >= N_W) begin
                slot = slot - N_W;
            end
            if (!found && req[slot[PTR_W-1:0]]) begin
                pick[slot[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART byte transmitter among N_REQ packet
// sources. A requester is granted for a whole packet (until its 'last' byte
// is accepted) and its bytes pass through a registered one-entry output stage.
//
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN
//   When defined, a granted requester that stalls (valid low) for TIMEOUT
//   cycles loses its grant and 'timeout' pulses for one cycle. When undefined
//   the grant is held until 'last' is accepted and 'timeout' is tied to 0.
//
// Ports:
//   clk                     in  : clock
//   rst                     in  : asynchronous reset, active low
//   req_valid [N_REQ-1:0]   in  : per-requester byte valid
//   req_data  [8*N_REQ-1:0] in  : byte of requester i in bits [8i+7:8i]
//   req_last  [N_REQ-1:0]   in  : byte is the last of its packet
//   req_ready [N_REQ-1:0]   out : byte of requester i accepted this cycle
//   tx_valid                out : output byte valid, stable until accepted
//   tx_data   [7:0]         out : output byte
//   tx_ready                in  : transmitter accepts tx_data
//   grant     [N_REQ-1:0]   out : registered one-hot grant, or zero
//   busy                    out : transfer in progress or byte buffered
//   timeout                 out : one-cycle pulse on stall-timer revoke
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_valid,
    output logic [BYTE_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    timeout
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;

    logic [N_REQ-1:0]   pick;
    logic               pick_any;
    logic [PTR_W-1:0]   g_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [BYTE_W-1:0]  sel_byte;
    logic               accept;
    logic               last_acc;
    logic               expired;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .any  (pick_any)
    );

    // Decode the registered one-hot grant into an index and route that
    // requester's byte; both are don't-care while grant is zero.
    always_comb begin
        g_idx    = '0;
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx    = PTR_W'(i);
                sel_byte = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign next_ptr = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + PTR_W'(1);

    // The stage can take a byte when empty or draining this cycle, which gives
    // back-to-back transfers without a bubble. grant is zero outside XFER.
    assign req_ready = grant_q & req_valid & {N_REQ{~tx_valid_q | tx_ready}};
    assign accept    = |req_ready;
    assign last_acc  = |(req_ready & req_last);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q;
    logic             stalled;

    assign stalled = ~|(grant_q & req_valid);
    assign expired = (state_q == XFER) && stalled && (stall_cnt_q == CNT_LIMIT);

    // Counts stalled cycles of the granted requester, saturating at the limit
    // so it never wraps back to a value that would hide the stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != XFER || accept) begin
            stall_cnt_d = '0;
        end else if (stalled && stall_cnt_q != CNT_LIMIT) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= expired;
        end
    end

    assign timeout = timeout_q;
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state logic. The output stage is updated independently of the
    // FSM so a buffered last byte keeps draining after the grant is dropped.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = sel_byte;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (last_acc || expired) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign grant    = grant_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q == XFER) | tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=8). Requesters
// are fed from per-requester byte queues; expected output bytes and expected
// grant order are queued when packets are loaded and popped when the DUT
// produces them. Build with UART_TX_ARB_TIMEOUT_EN to exercise the timer.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Stimulus sources and scoreboard
    logic [7:0] src_data [N][$];
    logic       src_last [N][$];
    logic       src_hold [N];
    logic       rdy_pat [$];
    logic [7:0] exp_q [$];
    int         exp_grant [$];

    // Monitor state
    logic       held_valid;
    logic [7:0] held_data;
    logic [N-1:0] prev_grant;
    int         cyc;
    int         out_first;
    int         out_last;
    int         g3_cycles;
    int         to_pulses;
    logic       watch_ignore;

    int n_checks;
    int n_pass;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic loadByte(input int r, input logic [7:0] d, input logic l);
        src_data[r].push_back(d);
        src_last[r].push_back(l);
    endtask

    // Load a packet of consecutive bytes and queue it as the next expected one
    task automatic loadPacket(input int r, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++) begin
            loadByte(r, base + 8'(k), (k == len - 1));
            exp_q.push_back(base + 8'(k));
        end
        exp_grant.push_back(r);
    endtask

    function automatic logic pending();
        for (int i = 0; i < N; i++) begin
            if (src_data[i].size() > 0 && !src_hold[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic monitor();
        int idx;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && src_data[i].size() > 0) begin
                void'(src_data[i].pop_front());
                void'(src_last[i].pop_front());
            end
        end
        if (held_valid) begin
            checkOutput("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, held_data}));
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("tx_extra_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                checkOutput("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            if (out_first < 0) out_first = cyc;
            out_last = cyc;
        end
        held_valid = tx_valid && !tx_ready;
        held_data  = tx_data;
        if (grant != '0 && prev_grant == '0) begin
            idx = -1;
            for (int i = 0; i < N; i++) if (grant[i]) idx = i;
            if (exp_grant.size() == 0) begin
                checkOutput("grant_extra", 32'(exp_grant.size()), 32'd1);
            end else begin
                checkOutput("grant_idx", 32'(idx), 32'(exp_grant.pop_front()));
            end
        end
        prev_grant = grant;
        if (grant[3]) g3_cycles++;
        if (timeout) to_pulses++;
        if (watch_ignore && grant[0]) begin
            checkOutput("ignored_ready3", 32'(req_ready[3]), 32'd0);
        end
    endtask

    // Runs n cycles; entered and left at 1 time unit after a rising edge
    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_data[i].size() > 0 && !src_hold[i]) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*8 +: 8]   = src_data[i][0];
                    req_last[i]          = src_last[i][0];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*8 +: 8]   = 8'h00;
                    req_last[i]          = 1'b0;
                end
            end
            if (rdy_pat.size() > 0) tx_ready = rdy_pat.pop_front();
            else                    tx_ready = 1'b1;
            @(negedge clk);
            monitor();
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runUntilIdle(input int budget, input string tag);
        int c;
        c = 0;
        while ((exp_q.size() > 0 || exp_grant.size() > 0 || pending() || busy) && c < budget) begin
            applyStimulus(1);
            c++;
        end
        checkOutput(tag, 32'(exp_q.size() + exp_grant.size()), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        n_checks = 0; n_pass = 0; cyc = 0;
        out_first = -1; out_last = -1;
        g3_cycles = 0; to_pulses = 0; watch_ignore = 1'b0;
        held_valid = 1'b0; held_data = '0; prev_grant = '0;
        for (int i = 0; i < N; i++) src_hold[i] = 1'b0;

        // Reset values, with requests asserted to show nothing is accepted
        rst = 1'b0; req_valid = '1; req_data = '0; req_last = '0; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst = 1'b1;

        // Round-robin fairness: 0,1,2,3,0 with one arbitration bubble each
        $display("[TB] round-robin fairness");
        loadPacket(0, 2, 8'h00);
        loadPacket(1, 2, 8'h10);
        loadPacket(2, 2, 8'h20);
        loadPacket(3, 2, 8'h30);
        loadPacket(0, 2, 8'h08);
        out_first = -1;
        runUntilIdle(100, "rr_drain");
        checkOutput("rr_span_cycles", 32'(out_last - out_first), 32'd13);

        // Reset mid-packet of requester 1 (pointer now at 1)
        $display("[TB] reset mid-packet");
        loadPacket(1, 4, 8'h40);
        c = 0;
        while (!(src_data[1].size() == 2 && tx_valid) && c < 20) begin
            applyStimulus(1);
            c++;
        end
        checkOutput("mid_pkt_reached", 32'(src_data[1].size()), 32'd2);
        checkOutput("mid_pkt_tx_valid", 32'(tx_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("async_rst_grant", 32'(grant), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_tx_data", 32'(tx_data), 32'd0);
        exp_q.delete();
        exp_grant.delete();
        for (int i = 0; i < N; i++) begin
            src_data[i].delete();
            src_last[i].delete();
            src_hold[i] = 1'b0;
        end
        held_valid = 1'b0;
        prev_grant = '0;
        req_valid  = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        loadPacket(0, 1, 8'h50);
        loadPacket(1, 1, 8'h51);
        runUntilIdle(50, "post_rst_drain");

        // Back-pressure on requester 2 (pointer now at 2)
        $display("[TB] back-pressure");
        loadByte(2, 8'hA5, 1'b0);
        loadByte(2, 8'h5A, 1'b0);
        loadByte(2, 8'hFF, 1'b1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hFF);
        exp_grant.push_back(2);
        for (int k = 0; k < 4; k++) begin
            rdy_pat.push_back(1'b1);
            rdy_pat.push_back(1'b0);
            rdy_pat.push_back(1'b0);
        end
        runUntilIdle(60, "bp_drain");
        rdy_pat.delete();

        // Single-byte packet on requester 3 and pointer wrap to 0
        $display("[TB] single-byte packet and wrap");
        g3_cycles = 0;
        loadPacket(3, 1, 8'h63);
        runUntilIdle(20, "single_drain");
        checkOutput("single_grant_cycles", 32'(g3_cycles), 32'd1);
        loadPacket(0, 1, 8'h70);
        loadPacket(3, 1, 8'h73);
        runUntilIdle(30, "wrap_drain");

        // Requester 3 asserts valid while requester 0 holds the grant
        $display("[TB] ignored requesters");
        watch_ignore = 1'b1;
        loadPacket(0, 4, 8'h80);
        c = 0;
        while (src_data[0].size() > 2 && c < 20) begin
            applyStimulus(1);
            c++;
        end
        src_hold[0] = 1'b1;
        loadPacket(3, 2, 8'h90);
        applyStimulus(4);
        checkOutput("ignore_grant_held", 32'(grant), 32'h1);
        src_hold[0] = 1'b0;
        runUntilIdle(40, "ignore_drain");
        watch_ignore = 1'b0;

        // Stall of granted requester 1 with requester 2 pending
        $display("[TB] stall timer");
        to_pulses = 0;
        loadByte(1, 8'hB0, 1'b0);
        loadByte(1, 8'hB1, 1'b1);
        loadByte(2, 8'hC0, 1'b1);
`ifdef UART_TX_ARB_TIMEOUT_EN
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hB1);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        exp_grant.push_back(1);
`else
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hC0);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
`endif
        c = 0;
        while (src_data[1].size() > 1 && c < 20) begin
            applyStimulus(1);
            c++;
        end
        src_hold[1] = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        c = 0;
        while (to_pulses == 0 && c < 30) begin
            applyStimulus(1);
            c++;
        end
        checkOutput("timeout_latency", 32'(c >= TO && c <= TO + 2), 32'd1);
        src_hold[1] = 1'b0;
        runUntilIdle(60, "timeout_drain");
        checkOutput("timeout_pulses", 32'(to_pulses), 32'd1);
`else
        applyStimulus(100);
        checkOutput("stall_grant_held", 32'(grant), 32'h2);
        checkOutput("stall_no_timeout", 32'(to_pulses), 32'd0);
        src_hold[1] = 1'b0;
        runUntilIdle(60, "stall_drain");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
